// File: rtl/ofdm_rx_pacer_pkg.sv
// Shared types for the OFDM RX sample pacer: IQ sample layout, pacer FSM states,
// underrun statistics width and its saturating-increment helper.
// Latency: n/a (types only). Backpressure: n/a.
package ofdm_rx_pacer_pkg;

    // Width of the underrun statistics counter.
    localparam int UNDERRUN_CNT_W = 16;

    // Default I/Q component width. The struct below uses it, so it describes
    // samples of a default-width build.
    localparam int IQ_DEFAULT_W = 12;

    typedef struct packed {
        logic signed [IQ_DEFAULT_W-1:0] i;
        logic signed [IQ_DEFAULT_W-1:0] q;
    } iq_sample_t;

    // DRAIN is reserved and never entered; any stray encoding recovers to IDLE.
    typedef enum logic [1:0] {
        PACER_IDLE  = 2'd0,
        PACER_RUN   = 2'd1,
        PACER_DRAIN = 2'd2
    } pacer_state_t;

    // Increment that sticks at all-ones.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        return (v == {UNDERRUN_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ofdm_rx_sync_fifo.sv
// Single-clock FIFO holding paced IQ samples, with a synchronous clear.
// Latency: a pushed word is poppable the cycle after the push; pop data is read combinationally.
// Backpressure: pushes while full and pops while empty are ignored; clr wins over both.
// Ports: clk/rst_n (async active-low), clr, push/push_dat, pop/pop_dat, full, empty, level.
module ofdm_rx_sync_fifo #(
    parameter int WIDTH_G = 24,
    parameter int DEPTH_G = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH_G-1:0]       push_dat,
    input  logic                     pop,
    output logic [WIDTH_G-1:0]       pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH_G):0] level
);

    localparam int AW = $clog2(DEPTH_G);
    localparam int LW = AW + 1;

    logic [WIDTH_G-1:0] mem_q [DEPTH_G];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (level_q == LW'(DEPTH_G));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !clr;
    assign pop_ok  = pop && !empty && !clr;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: it is only read behind a non-zero level.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/ofdm_rx_sample_pacer.sv
// Buffers upstream IQ samples and releases one per strobe period to the RX chain.
// Latency: strobe in cycle n pops; the sample is on rx_data_i/q with rx_data_valid in n+1.
// Backpressure: in_ready = FIFO not full (low in reset); empty strobes count as underruns.
// Ports: sys_clk, sys_rstn (async active-low), sys_init (sync clear), strobe_period (0 = pause),
//        in_i/in_q/in_valid/in_ready upstream, rx_data_i/q/valid/strobe downstream,
//        fifo_level occupancy, underrun_cnt saturating empty-strobe count.
// Build option: define OFDM_RX_PACER_STATS_EN to implement underrun_cnt; otherwise it reads 0.
module ofdm_rx_sample_pacer
    import ofdm_rx_pacer_pkg::*;
#(
    parameter int sample_bit_width_g = 12,
    parameter int fifo_depth_g       = 16,
    parameter int period_width_g     = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rstn,
    input  logic                          sys_init,
    input  logic [period_width_g-1:0]     strobe_period,
    input  logic [sample_bit_width_g-1:0] in_i,
    input  logic [sample_bit_width_g-1:0] in_q,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [sample_bit_width_g-1:0] rx_data_i,
    output logic [sample_bit_width_g-1:0] rx_data_q,
    output logic                          rx_data_valid,
    output logic                          rx_data_strobe,
    output logic [$clog2(fifo_depth_g):0] fifo_level,
    output logic [UNDERRUN_CNT_W-1:0]     underrun_cnt
);

    localparam int SW    = sample_bit_width_g;
    localparam int PAIRW = 2 * SW;

    pacer_state_t              state_q, state_d;
    logic [period_width_g-1:0] cnt_q, cnt_d;
    logic [period_width_g-1:0] cnt_inc;
    logic                      period_on;
    logic                      strobe_q, strobe_d;
    logic [SW-1:0]             rx_i_q, rx_i_d;
    logic [SW-1:0]             rx_q_q, rx_q_d;
    logic                      valid_q, valid_d;
    logic                      rdy_q, rdy_d;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic [PAIRW-1:0]          fifo_rd_dat;
    logic                      fifo_full;
    logic                      fifo_empty;

    // in_ready stays low through reset and rises on the first edge after it.
    assign rdy_d     = 1'b1;
    assign in_ready  = rdy_q && !fifo_full;
    // Samples offered during the sys_init cycle are dropped.
    assign fifo_push = in_valid && in_ready && !sys_init;
    // No bypass: the strobe only sees what was stored before this cycle.
    assign fifo_pop  = strobe_q && !fifo_empty && !sys_init;

    ofdm_rx_sync_fifo #(
        .WIDTH_G (PAIRW),
        .DEPTH_G (fifo_depth_g)
    ) u_fifo (
        .clk      (sys_clk),
        .rst_n    (sys_rstn),
        .clr      (sys_init),
        .push     (fifo_push),
        .push_dat ({in_i, in_q}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Pacer FSM and period counter. The counter never exceeds the largest
    // representable period minus one, so cnt_q + 1 cannot overflow. Comparing
    // with >= lets a shrunk period fire at once instead of wrapping round.
    always_comb begin
        period_on = (strobe_period != '0);
        cnt_inc   = cnt_q + 1'b1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        strobe_d  = 1'b0;
        case (state_q)
            PACER_IDLE: begin
                // Resume when there is (or is about to be) something to pace.
                if (period_on && (fifo_push || !fifo_empty)) begin
                    state_d = PACER_RUN;
                end
            end
            PACER_RUN: begin
                if (!period_on) begin
                    state_d = PACER_IDLE;
                end else if (cnt_inc >= strobe_period) begin
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = PACER_IDLE;
        endcase
        if (sys_init) begin
            state_d  = PACER_IDLE;
            cnt_d    = '0;
            strobe_d = 1'b0;
        end
    end

    // Output sample register: loads on pop, otherwise holds the last sample.
    always_comb begin
        rx_i_d  = rx_i_q;
        rx_q_d  = rx_q_q;
        valid_d = 1'b0;
        if (fifo_pop) begin
            rx_i_d  = fifo_rd_dat[PAIRW-1:SW];
            rx_q_d  = fifo_rd_dat[SW-1:0];
            valid_d = 1'b1;
        end
        if (sys_init) begin
            rx_i_d  = '0;
            rx_q_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q  <= PACER_IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            rx_i_q   <= '0;
            rx_q_q   <= '0;
            valid_q  <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            rx_i_q   <= rx_i_d;
            rx_q_q   <= rx_q_d;
            valid_q  <= valid_d;
            rdy_q    <= rdy_d;
        end
    end

    assign rx_data_i      = rx_i_q;
    assign rx_data_q      = rx_q_q;
    assign rx_data_valid  = valid_q;
    assign rx_data_strobe = strobe_q;

`ifdef OFDM_RX_PACER_STATS_EN
    logic [UNDERRUN_CNT_W-1:0] underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (strobe_q && fifo_empty) begin
            underrun_d = sat_inc(underrun_q);
        end
        if (sys_init) begin
            underrun_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_ofdm_rx_sample_pacer.sv
`timescale 1ns/1ps
module tb_ofdm_rx_sample_pacer;
    import ofdm_rx_pacer_pkg::*;

`ifdef OFDM_RX_PACER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        sys_init = 1'b0;
    logic [7:0]  strobe_period = 8'd0;
    logic [11:0] in_i = 12'd0;
    logic [11:0] in_q = 12'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] rx_data_i, rx_data_q;
    logic        rx_data_valid, rx_data_strobe;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        iq_sample_t s;
    } obs_t;

    obs_t vq[$];
    int   sq[$];
    obs_t mon_o;

    ofdm_rx_sample_pacer dut (
        .sys_clk        (sys_clk),
        .sys_rstn       (sys_rstn),
        .sys_init       (sys_init),
        .strobe_period  (strobe_period),
        .in_i           (in_i),
        .in_q           (in_q),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .rx_data_i      (rx_data_i),
        .rx_data_q      (rx_data_q),
        .rx_data_valid  (rx_data_valid),
        .rx_data_strobe (rx_data_strobe),
        .fifo_level     (fifo_level),
        .underrun_cnt   (underrun_cnt)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record every valid sample and every strobe with the cycle it was seen in.
    always @(negedge sys_clk) begin
        if (rx_data_valid === 1'b1) begin
            mon_o.c   = cyc;
            mon_o.s.i = rx_data_i;
            mon_o.s.q = rx_data_q;
            vq.push_back(mon_o);
        end
        if (rx_data_strobe === 1'b1) sq.push_back(cyc);
    end

    function automatic iq_sample_t smp(input int k);
        iq_sample_t s;
        s.i = 12'(k * 37 + 5);
        s.q = 12'(4000 - k * 11);
        return s;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample_at(input int t);
        while (cyc < t) tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic drive(input iq_sample_t s);
        in_valid = 1'b1;
        in_i     = s.i;
        in_q     = s.q;
    endtask

    task automatic do_init();
        tick();
        sys_init = 1'b1;
        tick();
        sys_init = 1'b0;
    endtask

    task automatic test_reset();
        sys_rstn = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++; if (rx_data_valid !== 1'b0 || rx_data_strobe !== 1'b0) begin errors++; $display("FAIL reset_valid_strobe: got valid=%b strobe=%b, expected 0 0", rx_data_valid, rx_data_strobe); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d, expected 0", fifo_level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
        checks++; if (rx_data_i !== 12'd0 || rx_data_q !== 12'd0) begin errors++; $display("FAIL reset_data: got %h/%h, expected 000/000", rx_data_i, rx_data_q); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_underrun: got %0d, expected 0", underrun_cnt); end
        tick();
        sys_rstn = 1'b1;
        @(negedge sys_clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b, expected 0", in_ready); end
        @(negedge sys_clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b, expected 1", in_ready); end
    endtask

    task automatic test_period24();
        int p;
        vq.delete(); sq.delete();
        strobe_period = 8'd24;
        tick();
        p = cyc;
        for (int k = 0; k < 8; k++) begin
            drive(smp(k));
            tick();
        end
        in_valid = 1'b0;
        sample_at(p + 250);
        checks++; if (vq.size() != 8) begin errors++; $display("FAIL p24_count: got %0d valids, expected 8", vq.size()); end
        for (int k = 0; k < 8 && k < vq.size(); k++) begin
            checks++;
            if (vq[k].c != p + 26 + 24 * k || vq[k].s !== smp(k)) begin
                errors++; $display("FAIL p24_sample%0d: got cycle %0d data %h, expected cycle %0d data %h", k, vq[k].c - p, vq[k].s, 26 + 24 * k, smp(k));
            end
        end
        checks++; if (sq.size() != 10) begin errors++; $display("FAIL p24_strobe_count: got %0d, expected 10", sq.size()); end
        for (int k = 0; k < 10 && k < sq.size(); k++) begin
            checks++;
            if (sq[k] != p + 25 + 24 * k) begin errors++; $display("FAIL p24_strobe%0d: got cycle %0d, expected %0d", k, sq[k] - p, 25 + 24 * k); end
        end
        checks++; if (underrun_cnt !== 16'(2 * STATS)) begin errors++; $display("FAIL p24_underrun: got %0d, expected %0d", underrun_cnt, 2 * STATS); end
    endtask

    task automatic test_back_to_back();
        int p;
        int not_ready;
        do_init();
        vq.delete(); sq.delete();
        strobe_period = 8'd1;
        p = cyc;
        not_ready = 0;
        for (int k = 0; k < 20; k++) begin
            drive(smp(100 + k));
            if (in_ready !== 1'b1) not_ready++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (not_ready != 0) begin errors++; $display("FAIL b2b_ready: in_ready low in %0d push cycles, expected 0", not_ready); end
        sample_at(p + 22);
        checks++; if (vq.size() != 20) begin errors++; $display("FAIL b2b_count: got %0d valids, expected 20", vq.size()); end
        for (int k = 0; k < 20 && k < vq.size(); k++) begin
            checks++;
            if (vq[k].c != p + 3 + k || vq[k].s !== smp(100 + k)) begin
                errors++; $display("FAIL b2b_sample%0d: got cycle %0d data %h, expected cycle %0d data %h", k, vq[k].c - p, vq[k].s, 3 + k, smp(100 + k));
            end
        end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL b2b_no_underrun: got %0d, expected 0", underrun_cnt); end
        sample_at(p + 30);
        checks++; if (underrun_cnt !== 16'(8 * STATS)) begin errors++; $display("FAIL b2b_empty_strobes: got %0d, expected %0d", underrun_cnt, 8 * STATS); end
        checks++; if (vq.size() != 20) begin errors++; $display("FAIL b2b_no_extra: got %0d valids, expected 20", vq.size()); end
    endtask

    task automatic test_full();
        int idx, guard, max_lvl, bad_lvl, bad_rdy, bad_dat, bad_sp;
        bit reached, fire;
        do_init();
        vq.delete(); sq.delete();
        strobe_period = 8'd4;
        idx = 0; guard = 0; max_lvl = 0; bad_lvl = 0; bad_rdy = 0; reached = 1'b0;
        drive(smp(200));
        while (idx < 100 && guard < 2000) begin
            fire = in_ready;
            if (fifo_level == 5'd16 && in_ready !== 1'b0) bad_rdy++;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (reached && fifo_level != 5'd15 && fifo_level != 5'd16) bad_lvl++;
            if (fifo_level == 5'd16) reached = 1'b1;
            tick();
            guard++;
            if (fire) begin
                idx++;
                drive(smp(200 + idx));
            end
        end
        in_valid = 1'b0;
        checks++; if (idx != 100) begin errors++; $display("FAIL full_timeout: pushed %0d, expected 100", idx); end
        checks++; if (max_lvl != 16) begin errors++; $display("FAIL full_max_level: got %0d, expected 16", max_lvl); end
        checks++; if (bad_rdy != 0) begin errors++; $display("FAIL full_ready_at_16: got %0d cycles ready while full, expected 0", bad_rdy); end
        checks++; if (bad_lvl != 0) begin errors++; $display("FAIL full_steady_level: got %0d cycles outside 15/16, expected 0", bad_lvl); end
        sample_at(cyc + 100);
        bad_dat = 0; bad_sp = 0;
        for (int k = 0; k < vq.size(); k++) begin
            if (vq[k].s !== smp(200 + k)) bad_dat++;
            if (k > 0 && vq[k].c - vq[k-1].c != 4) bad_sp++;
        end
        checks++; if (vq.size() != 100) begin errors++; $display("FAIL full_count: got %0d valids, expected 100", vq.size()); end
        checks++; if (bad_dat != 0) begin errors++; $display("FAIL full_order: got %0d out-of-order samples, expected 0", bad_dat); end
        checks++; if (bad_sp != 0) begin errors++; $display("FAIL full_spacing: got %0d gaps not 4, expected 0", bad_sp); end
    endtask

    task automatic test_period_change();
        int p;
        do_init();
        vq.delete(); sq.delete();
        strobe_period = 8'd24;
        p = cyc;
        drive(smp(300));
        tick();
        in_valid = 1'b0;
        while (cyc < p + 11) tick();
        strobe_period = 8'd6;
        sample_at(p + 31);
        checks++; if (sq.size() != 4) begin errors++; $display("FAIL chg_strobe_count: got %0d, expected 4", sq.size()); end
        for (int k = 0; k < 4 && k < sq.size(); k++) begin
            checks++;
            if (sq[k] != p + 12 + 6 * k) begin errors++; $display("FAIL chg_strobe%0d: got cycle %0d, expected %0d", k, sq[k] - p, 12 + 6 * k); end
        end
        checks++;
        if (vq.size() != 1 || vq[0].c != p + 13 || vq[0].s !== smp(300)) begin
            errors++; $display("FAIL chg_sample: got %0d valids, expected 1 at cycle 13 with %h", vq.size(), smp(300));
        end
        checks++; if (underrun_cnt !== 16'(3 * STATS)) begin errors++; $display("FAIL chg_underrun: got %0d, expected %0d", underrun_cnt, 3 * STATS); end
    endtask

    task automatic test_init();
        int p, late_v, late_s;
        iq_sample_t held;
        do_init();
        vq.delete(); sq.delete();
        strobe_period = 8'd2;
        p = cyc;
        drive(smp(400));
        tick();
        in_valid = 1'b0;
        while (cyc < p + 10) tick();
        strobe_period = 8'd0;
        held = smp(400);
        checks++; if (underrun_cnt !== 16'(3 * STATS)) begin errors++; $display("FAIL init_pre_underrun: got %0d, expected %0d", underrun_cnt, 3 * STATS); end
        checks++; if (rx_data_i !== held.i || rx_data_q !== held.q) begin errors++; $display("FAIL init_hold_data: got %h/%h, expected %h/%h", rx_data_i, rx_data_q, held.i, held.q); end
        for (int k = 0; k < 7; k++) begin
            drive(smp(401 + k));
            tick();
        end
        checks++; if (fifo_level !== 5'd7) begin errors++; $display("FAIL init_pre_level: got %0d, expected 7", fifo_level); end
        sys_init = 1'b1;
        drive(smp(999));
        tick();
        sys_init = 1'b0;
        in_valid = 1'b0;
        @(negedge sys_clk); #1;
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL init_level: got %0d, expected 0", fifo_level); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL init_underrun: got %0d, expected 0", underrun_cnt); end
        checks++; if (rx_data_valid !== 1'b0 || rx_data_i !== 12'd0 || rx_data_q !== 12'd0) begin errors++; $display("FAIL init_outputs: got valid=%b data=%h/%h, expected 0 000/000", rx_data_valid, rx_data_i, rx_data_q); end
        strobe_period = 8'd2;
        sample_at(p + 30);
        late_v = 0; late_s = 0;
        foreach (vq[k]) if (vq[k].c > p + 4) late_v++;
        foreach (sq[k]) if (sq[k] > p + 9) late_s++;
        checks++; if (late_v != 0) begin errors++; $display("FAIL init_no_valid: got %0d valids after pause/init, expected 0", late_v); end
        checks++; if (late_s != 0) begin errors++; $display("FAIL init_no_strobe: got %0d strobes after pause/init, expected 0", late_s); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL init_discard: got level %0d, expected 0", fifo_level); end
        drive(smp(500));
        tick();
        in_valid = 1'b0;
        sample_at(p + 36);
        checks++;
        if (vq.size() == 0 || vq[vq.size()-1].c != p + 34 || vq[vq.size()-1].s !== smp(500)) begin
            errors++; $display("FAIL init_restart: got %0d valids, expected last at cycle 34 with %h", vq.size(), smp(500));
        end
    endtask

    task automatic test_async_reset();
        do_init();
        vq.delete(); sq.delete();
        strobe_period = 8'd1;
        for (int k = 0; k < 6; k++) begin
            drive(smp(600 + k));
            tick();
        end
        @(negedge sys_clk); #2;
        checks++; if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b, expected 1", rx_data_valid); end
        sys_rstn = 1'b0;
        #1;
        checks++; if (rx_data_valid !== 1'b0 || rx_data_strobe !== 1'b0) begin errors++; $display("FAIL arst_valid_strobe: got valid=%b strobe=%b, expected 0 0", rx_data_valid, rx_data_strobe); end
        checks++; if (fifo_level !== 5'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL arst_level_ready: got level=%0d ready=%b, expected 0 0", fifo_level, in_ready); end
        checks++; if (rx_data_i !== 12'd0 || rx_data_q !== 12'd0 || underrun_cnt !== 16'd0) begin errors++; $display("FAIL arst_data: got %h/%h underrun=%0d, expected 000/000 0", rx_data_i, rx_data_q, underrun_cnt); end
        in_valid = 1'b0;
        tick();
        tick();
        sys_rstn = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready_return: got %b, expected 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_period24();
        test_back_to_back();
        test_full();
        test_period_change();
        test_init();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ofdm_rx_sample_pacer.md
OFDM_RX_SAMPLE_PACER -- requirements
Module: ofdm_rx_sample_pacer

Interface
REQ-001 Parameter sample_bit_width_g, default 12, width of each I and Q sample.
REQ-002 Parameter fifo_depth_g, default 16, FIFO entries; power of two, minimum 2.
REQ-003 Parameter period_width_g, default 8, width of the strobe period input.
REQ-004 sys_clk  in  1  single clock; all logic is rising-edge.
REQ-005 sys_rstn  in  1  asynchronous active-low reset.
REQ-006 sys_init  in  1  synchronous clear pulse.
REQ-007 strobe_period  in  period_width_g  sample period in clocks; 0 = paused.
REQ-008 in_i, in_q  in  sample_bit_width_g each  upstream sample, signed.
REQ-009 in_valid  in  1 / in_ready  out  1  upstream valid/ready handshake.
REQ-010 rx_data_i, rx_data_q  out  sample_bit_width_g each  paced sample to the RX chain.
REQ-011 rx_data_valid  out  1  one-cycle pulse per paced sample.
REQ-012 rx_data_strobe  out  1  one-cycle pulse at every period boundary.
REQ-013 fifo_level  out  $clog2(fifo_depth_g)+1  current occupancy.
REQ-014 underrun_cnt  out  16  saturating count of strobes that found the FIFO empty.

Function
REQ-015 Push SHALL occur when in_valid and in_ready are both 1; in_ready SHALL equal (fifo_level < fifo_depth_g).
REQ-016 The strobe counter SHALL increment each cycle while strobe_period /= 0; when the incremented value >= strobe_period, rx_data_strobe SHALL pulse and the counter SHALL return to 0.
REQ-017 strobe_period = 1 SHALL strobe every cycle; strobe_period = 0 SHALL hold the counter and suppress strobes.
REQ-018 A strobe_period change SHALL take effect immediately via the >= compare; no strobe is lost or duplicated.
REQ-019 A strobe in cycle n with FIFO non-empty SHALL pop; the popped sample SHALL appear on rx_data_i/q with rx_data_valid=1 in cycle n+1.
REQ-020 A strobe with FIFO empty SHALL not assert rx_data_valid, SHALL hold rx_data_i/q, and SHALL increment underrun_cnt (saturating at 16'hFFFF).
REQ-021 No bypass: a push and a strobe in the same cycle on an empty FIFO SHALL count as an underrun; the pushed sample waits for the next strobe.
REQ-022 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave fifo_level unchanged.
REQ-023 Read/write pointers SHALL wrap modulo fifo_depth_g; order SHALL be strict FIFO.
REQ-024 Pacer state SHALL be a 3-state FSM: IDLE (period 0 or FIFO never filled), RUN (strobing), DRAIN unused -- IDLE->RUN on first push with period /= 0; RUN->IDLE on sys_init or period = 0.
REQ-025 sys_init SHALL, on the next edge, empty the FIFO, zero the counter, underrun_cnt, rx_data_i/q, rx_data_valid, rx_data_strobe, and enter IDLE; pushes in the sys_init cycle are discarded.

Reset
REQ-026 sys_rstn = 0 SHALL asynchronously force: rx_data_i/q = 0, rx_data_valid = 0, rx_data_strobe = 0, fifo_level = 0, underrun_cnt = 0, in_ready = 0, FSM = IDLE, counter = 0.
REQ-027 in_ready SHALL rise on the first clock edge after reset deassertion.

Configuration
REQ-028 Macro OFDM_RX_PACER_STATS_EN defined: underrun_cnt SHALL behave per REQ-020.
REQ-029 Macro OFDM_RX_PACER_STATS_EN undefined: underrun_cnt SHALL be tied to 0 with no counter register; all other behaviour is identical.

Structure
REQ-030 Package ofdm_rx_pacer_pkg SHALL hold the IQ sample struct typedef, the pacer FSM state enum and the underrun counter width constant (16).
REQ-031 Storage SHALL be a sub-module ofdm_rx_sync_fifo (parametrised width/depth, push/pop/full/empty/level); pacing logic stays in the top.

Verification
REQ-032 Period 24, push 8 samples, never refill -> 8 rx_data_valid pulses spaced exactly 24 cycles, each 1 cycle after rx_data_strobe; data in push order; underrun_cnt increments once per subsequent strobe.
REQ-033 Period 1, depth 16, 20 back-to-back pushes -> in_ready never drops below level 16, output streams every cycle, no underrun.
REQ-034 Period 4, upstream holds in_valid, depth 16 -> in_ready low at level 16; level steady at 15/16 once pacing; no sample lost or duplicated over 100 samples.
REQ-035 Change period 24->6 while counter is 10 -> strobe on the next cycle, then every 6 cycles.
REQ-036 sys_init pulse with level 7 and underrun_cnt 3 -> next cycle level 0, underrun_cnt 0, no rx_data_valid until new pushes and next strobe.
REQ-037 Assert sys_rstn = 0 mid-stream between edges -> outputs zero immediately without a clock edge; build without OFDM_RX_PACER_STATS_EN -> underrun_cnt constant 0.
